// File: rtl/cordic_param_fifo.sv
// cordic_param_fifo: parametrised single-clock FIFO with standard or first-word-fall-through read,
// registered threshold flags, occupancy count and overflow/underflow pulses.
module cordic_param_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 512,
   parameter int FWFT  = 0,
   parameter int AFVAL = 508,
   parameter int AEVAL = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DATA,
   input  logic             WE,
   input  logic             RE,
   output logic [WIDTH-1:0] Q,
   output logic             DVLD,
   output logic             FULL,
   output logic             EMPTY,
   output logic             AFULL,
   output logic             AEMPTY,
   output logic             OVERFLOW,
   output logic             UNDERFLOW,
   output logic [AW:0]      WRCNT
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdat;
   logic [AW-1:0]    wptr, rptr;
   logic [AW:0]      cnt_n;
   logic             wr, rd, ld, ov_n, rd_d;
   // In FWFT mode the output stage holds one word, so RAM occupancy is WRCNT minus that word.
   always_comb begin
      wr    = WE && !FULL;
      rd    = RE && !EMPTY;
      cnt_n = WRCNT + (AW+1)'(wr) - (AW+1)'(rd);
      ld    = FWFT != 0 ? (WRCNT != (AW+1)'(!EMPTY)) && (EMPTY || rd) : rd;
      ov_n  = ld || (!EMPTY && !rd);
   end
   always_ff @(posedge CLK) begin
      if (wr && !RESET) mem[wptr] <= DATA;
      rdat <= mem[rptr];
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wptr      <= '0;
         rptr      <= '0;
         WRCNT     <= '0;
         Q         <= '0;
         DVLD      <= 1'b0;
         FULL      <= 1'b0;
         EMPTY     <= 1'b1;
         AFULL     <= 1'b0;
         AEMPTY    <= 1'b1;
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
         rd_d      <= 1'b0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (ld) rptr <= rptr + 1'b1;
         WRCNT     <= cnt_n;
         FULL      <= cnt_n == (AW+1)'(DEPTH);
         AFULL     <= cnt_n >= (AW+1)'(AFVAL);
         AEMPTY    <= cnt_n <= (AW+1)'(AEVAL);
         OVERFLOW  <= WE && FULL;
         UNDERFLOW <= RE && EMPTY;
         rd_d      <= rd;
         EMPTY     <= FWFT != 0 ? !ov_n : cnt_n == '0;
         DVLD      <= FWFT != 0 ? ov_n : rd_d;
         // Standard mode presents the word one edge after the RAM read to give one full cycle of latency.
         if (FWFT != 0 ? ld : rd_d) Q <= FWFT != 0 ? mem[rptr] : rdat;
      end
   end
endmodule

// File: tb/tb_cordic_param_fifo.sv
// tb_cordic_param_fifo: directed checks of a standard 32x512 instance and a FWFT 8x16 instance,
// finishing with a queue-model scoreboard run on the standard instance.
module tb_cordic_param_fifo;
   logic        clk = 1'b0;
   logic        rst0, rst1;
   logic [31:0] d0, q0;
   logic        we0, re0, dvld0, full0, empty0, afull0, aempty0, ovf0, unf0;
   logic [9:0]  wrcnt0;
   logic [7:0]  d1, q1;
   logic        we1, re1, dvld1, full1, empty1, afull1, aempty1, ovf1, unf1;
   logic [4:0]  wrcnt1;
   int          n_asrt = 0, n_fail = 0;

   always #5 clk = ~clk;

   cordic_param_fifo u0 (
      .CLK(clk), .RESET(rst0), .DATA(d0), .WE(we0), .RE(re0), .Q(q0), .DVLD(dvld0),
      .FULL(full0), .EMPTY(empty0), .AFULL(afull0), .AEMPTY(aempty0),
      .OVERFLOW(ovf0), .UNDERFLOW(unf0), .WRCNT(wrcnt0)
   );

   cordic_param_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AFVAL(14), .AEVAL(2)) u1 (
      .CLK(clk), .RESET(rst1), .DATA(d1), .WE(we1), .RE(re1), .Q(q1), .DVLD(dvld1),
      .FULL(full1), .EMPTY(empty1), .AFULL(afull1), .AEMPTY(aempty1),
      .OVERFLOW(ovf1), .UNDERFLOW(unf1), .WRCNT(wrcnt1)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] mq[$];
      logic [31:0] c_val, prv_val;
      logic        c_rd, c_wr, prv_rd, e_ovf, e_unf;
      rst0 = 1'b1; rst1 = 1'b1;
      we0 = 1'b0; re0 = 1'b0; d0 = '0;
      we1 = 1'b0; re1 = 1'b0; d1 = '0;
      step; step;
      rst0 = 1'b0; rst1 = 1'b0;
      chk("rst0_q", q0, 0);          chk("rst0_dvld", dvld0, 0);   chk("rst0_full", full0, 0);
      chk("rst0_empty", empty0, 1);  chk("rst0_afull", afull0, 0); chk("rst0_aempty", aempty0, 1);
      chk("rst0_ovf", ovf0, 0);      chk("rst0_unf", unf0, 0);     chk("rst0_wrcnt", wrcnt0, 0);
      chk("rst1_q", q1, 0);          chk("rst1_dvld", dvld1, 0);   chk("rst1_empty", empty1, 1);
      chk("rst1_aempty", aempty1, 1); chk("rst1_wrcnt", wrcnt1, 0);

      // underflow on idle standard FIFO
      re0 = 1'b1; step; re0 = 1'b0;
      chk("unf_pulse", unf0, 1); chk("unf_wrcnt", wrcnt0, 0); chk("unf_empty", empty0, 1);
      step;
      chk("unf_clear", unf0, 0);

      // FWFT single word: EMPTY lags WRCNT by one edge
      we1 = 1'b1; d1 = 8'hA5; step; we1 = 1'b0;
      chk("fw_cnt1", wrcnt1, 1); chk("fw_empty_lag", empty1, 1);
      step;
      chk("fw_q_a5", q1, 8'hA5); chk("fw_empty0", empty1, 0); chk("fw_dvld", dvld1, 1);
      re1 = 1'b1; step; re1 = 1'b0;
      chk("fw_pop_empty", empty1, 1); chk("fw_pop_cnt", wrcnt1, 0); chk("fw_pop_dvld", dvld1, 0);

      // FWFT burst to full
      for (int i = 0; i < 16; i++) begin
         we1 = 1'b1; d1 = 8'(8'h10 + i); step;
         chk("fw_burst_cnt", wrcnt1, i + 1);
      end
      we1 = 1'b0;
      chk("fw_full", full1, 1); chk("fw_afull", afull1, 1); chk("fw_aempty", aempty1, 0);
      chk("fw_head", q1, 8'h10); chk("fw_nempty", empty1, 0);

      // full FIFO with simultaneous WE and RE: read wins, write rejected
      we1 = 1'b1; re1 = 1'b1; d1 = 8'hEE; step; we1 = 1'b0; re1 = 1'b0;
      chk("fw_wr_rd_cnt", wrcnt1, 15); chk("fw_wr_rd_full", full1, 0);
      chk("fw_wr_rd_ovf", ovf1, 1);    chk("fw_wr_rd_q", q1, 8'h11);
      step;
      chk("fw_ovf_clear", ovf1, 0);
      for (int i = 0; i < 15; i++) begin
         re1 = 1'b1; step;
         if (i == 14) re1 = 1'b0;
         chk("fw_drain_cnt", wrcnt1, 14 - i);
         chk("fw_drain_aempty", aempty1, (14 - i) <= 2);
         chk("fw_drain_afull", afull1, (14 - i) >= 14);
         chk("fw_drain_empty", empty1, i == 14);
         if (i < 14) chk("fw_drain_q", q1, 8'(8'h12 + i));
      end
      re1 = 1'b1; step; re1 = 1'b0;
      chk("fw_unf", unf1, 1);

      // standard: fill to full
      for (int i = 0; i < 512; i++) begin
         we0 = 1'b1; d0 = i; step;
         chk("fill_cnt", wrcnt0, i + 1);
         chk("fill_afull", afull0, (i + 1) >= 508);
         chk("fill_full", full0, i == 511);
         chk("fill_empty", empty0, 0);
      end
      d0 = 32'd999; step; we0 = 1'b0;
      chk("ovf_pulse", ovf0, 1); chk("ovf_cnt", wrcnt0, 512);
      step;
      chk("ovf_clear", ovf0, 0);

      // standard: drain, Q one cycle after the accepting edge
      re0 = 1'b1;
      for (int i = 0; i < 512; i++) begin
         step;
         if (i == 511) re0 = 1'b0;
         chk("drain_dvld", dvld0, i > 0);
         if (i > 0) chk("drain_q", q0, i - 1);
      end
      chk("drain_empty", empty0, 1); chk("drain_cnt", wrcnt0, 0);
      step;
      chk("drain_last_q", q0, 511); chk("drain_last_dvld", dvld0, 1);
      step;
      chk("drain_hold_q", q0, 511); chk("drain_hold_dvld", dvld0, 0);

      // half full, streaming across pointer wrap
      for (int i = 0; i < 256; i++) begin
         we0 = 1'b1; d0 = 1000 + i; step;
      end
      chk("half_cnt", wrcnt0, 256);
      for (int j = 0; j < 2000; j++) begin
         we0 = 1'b1; re0 = 1'b1; d0 = 1256 + j; step;
         chk("stream_cnt", wrcnt0, 256);
         chk("stream_flags", {ovf0, unf0}, 0);
         if (j > 0) chk("stream_q", q0, 1000 + j - 1);
      end
      we0 = 1'b0; re0 = 1'b0;

      // reset mid-traffic at 300 words
      for (int i = 0; i < 44; i++) begin
         we0 = 1'b1; d0 = 32'hBAD0_0000 + i; step;
      end
      chk("pre_rst_cnt", wrcnt0, 300);
      rst0 = 1'b1; step; rst0 = 1'b0; we0 = 1'b0;
      chk("mid_rst_cnt", wrcnt0, 0); chk("mid_rst_empty", empty0, 1);
      chk("mid_rst_q", q0, 0);       chk("mid_rst_dvld", dvld0, 0);
      we0 = 1'b1; d0 = 32'h1234; step;
      d0 = 32'h5678; step; we0 = 1'b0;
      re0 = 1'b1; step; step; re0 = 1'b0;
      chk("post_rst_q0", q0, 32'h1234);
      step;
      chk("post_rst_q1", q0, 32'h5678); chk("post_rst_empty", empty0, 1);

      // random traffic against a queue model, biased to reach full then empty
      prv_rd = 1'b0; prv_val = '0; c_val = '0;
      for (int k = 0; k < 3000; k++) begin
         we0 = $urandom_range(7) < (k < 1500 ? 7 : 3);
         re0 = $urandom_range(7) < (k < 1500 ? 3 : 7);
         d0  = $urandom;
         e_ovf = we0 && mq.size() == 512;
         e_unf = re0 && mq.size() == 0;
         c_wr  = we0 && mq.size() < 512;
         c_rd  = re0 && mq.size() > 0;
         if (c_rd) c_val = mq.pop_front();
         if (c_wr) mq.push_back(d0);
         step;
         chk("rnd_cnt", wrcnt0, mq.size());
         chk("rnd_full", full0, mq.size() == 512);
         chk("rnd_empty", empty0, mq.size() == 0);
         chk("rnd_ovf", ovf0, e_ovf);
         chk("rnd_unf", unf0, e_unf);
         chk("rnd_dvld", dvld0, prv_rd);
         if (prv_rd) chk("rnd_q", q0, prv_val);
         prv_rd = c_rd;
         prv_val = c_val;
      end
      we0 = 1'b0; re0 = 1'b0;
      step;
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
